// File: rtl/sign_narrow.sv
// Narrows a signed IN_W-bit word to OUT_W bits, saturating or wrapping out-of-range values,
// behind a single-register valid/ready stage with sticky overflow and a saturating event count.
module sign_narrow #(
  parameter int IN_W   = 32,
  parameter int OUT_W  = 16,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  input  logic             clr,
  output logic             ovf_sticky,
  output logic [7:0]       sat_cnt
);

  localparam int HEAD_W = IN_W - OUT_W + 1;

  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  logic [HEAD_W-1:0] head;
  logic              in_range;
  logic              in_xfer;
  logic [OUT_W-1:0]  narrowed;

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;

  // The word fits iff every bit from the sign down to the new sign position agrees.
  assign head     = in_data[IN_W-1:OUT_W-1];
  assign in_range = (head == '0) || (head == '1);

  always_comb begin
    narrowed = in_data[OUT_W-1:0];
    if (SAT_EN && !in_range) begin
      narrowed = in_data[IN_W-1] ? MIN_NEG : MAX_POS;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= narrowed;
      out_sat   <= !in_range;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear wins over a same-cycle out-of-range acceptance; the count sticks at its ceiling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_sticky <= 1'b0;
      sat_cnt    <= '0;
    end else if (clr) begin
      ovf_sticky <= 1'b0;
      sat_cnt    <= '0;
    end else if (in_xfer && !in_range) begin
      ovf_sticky <= 1'b1;
      if (sat_cnt != 8'hFF) begin
        sat_cnt <= sat_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sign_narrow.sv
// Directed bench for sign_narrow: a saturating instance (default) and a wrapping instance
// share the same stimulus; each task checks its own feature against hand-computed values.
module tb_sign_narrow;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        clr;

  logic        in_ready, out_valid, out_sat, ovf_sticky;
  logic [15:0] out_data;
  logic [7:0]  sat_cnt;

  logic        w_in_ready, w_out_valid, w_out_sat, w_ovf_sticky;
  logic [15:0] w_out_data;
  logic [7:0]  w_sat_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sign_narrow dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .clr(clr), .ovf_sticky(ovf_sticky), .sat_cnt(sat_cnt)
  );

  sign_narrow #(.IN_W(32), .OUT_W(16), .SAT_EN(1'b0)) dut_wrap (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data), .out_sat(w_out_sat),
    .clr(clr), .ovf_sticky(w_ovf_sticky), .sat_cnt(w_sat_cnt)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr = 1'b0;
    #2;
    n_checks++;
    if ({out_valid, out_data, out_sat, ovf_sticky, sat_cnt} !== 27'd0) begin
      $display("FAIL reset_outputs: got valid=%b data=%h sat=%b ovf=%b cnt=%0d, want all 0",
               out_valid, out_data, out_sat, ovf_sticky, sat_cnt);
      n_fail++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b want 1", in_ready); n_fail++;
    end
    step(); step();
    #2 reset_n = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL post_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      n_fail++;
    end
  endtask

  task automatic test_in_range();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hFFFF8001;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h8001 || out_sat !== 1'b0) begin
      $display("FAIL in_range_neg: got v=%b d=%h s=%b want 1/8001/0", out_valid, out_data, out_sat);
      n_fail++;
    end
    in_data = 32'h00007FFF;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h7FFF || out_sat !== 1'b0) begin
      $display("FAIL in_range_pos: got v=%b d=%h s=%b want 1/7FFF/0", out_valid, out_data, out_sat);
      n_fail++;
    end
    // Most negative in-range word: sign-extends back to the original input.
    in_data = 32'hFFFF8000;
    step();
    n_checks++;
    if (out_data !== 16'h8000 || out_sat !== 1'b0 || {{16{out_data[15]}}, out_data} !== in_data) begin
      $display("FAIL in_range_edge: got d=%h s=%b want 8000/0", out_data, out_sat);
      n_fail++;
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h8000) begin
      $display("FAIL drain_hold: got v=%b d=%h want 0/8000", out_valid, out_data);
      n_fail++;
    end
    n_checks++;
    if (ovf_sticky !== 1'b0 || sat_cnt !== 8'd0) begin
      $display("FAIL no_ovf: got ovf=%b cnt=%0d want 0/0", ovf_sticky, sat_cnt); n_fail++;
    end
  endtask

  task automatic test_saturate();
    in_valid = 1'b1; in_data = 32'h00008000;
    step();
    n_checks++;
    if (out_data !== 16'h7FFF || out_sat !== 1'b1) begin
      $display("FAIL sat_pos: got d=%h s=%b want 7FFF/1", out_data, out_sat); n_fail++;
    end
    n_checks++;
    if (w_out_data !== 16'h8000 || w_out_sat !== 1'b1) begin
      $display("FAIL wrap_pos: got d=%h s=%b want 8000/1", w_out_data, w_out_sat); n_fail++;
    end
    in_data = 32'h80000000;
    step();
    n_checks++;
    if (out_data !== 16'h8000 || out_sat !== 1'b1) begin
      $display("FAIL sat_neg: got d=%h s=%b want 8000/1", out_data, out_sat); n_fail++;
    end
    in_data = 32'hFFFF7FFF;
    in_valid = 1'b0;
    step();
    n_checks++;
    if (ovf_sticky !== 1'b1 || sat_cnt !== 8'd2) begin
      $display("FAIL sat_stats: got ovf=%b cnt=%0d want 1/2", ovf_sticky, sat_cnt); n_fail++;
    end
    // Just below the most negative in-range word.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_data !== 16'h8000 || out_sat !== 1'b1 || sat_cnt !== 8'd3) begin
      $display("FAIL sat_edge: got d=%h s=%b cnt=%0d want 8000/1/3", out_data, out_sat, sat_cnt);
      n_fail++;
    end
  endtask

  task automatic test_wrap();
    clr = 1'b1;
    step();
    clr = 1'b0;
    in_valid = 1'b1; in_data = 32'h00012345;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (w_out_data !== 16'h2345 || w_out_sat !== 1'b1 || w_sat_cnt !== 8'd1 || w_ovf_sticky !== 1'b1) begin
      $display("FAIL wrap_trunc: got d=%h s=%b cnt=%0d ovf=%b want 2345/1/1/1",
               w_out_data, w_out_sat, w_sat_cnt, w_ovf_sticky);
      n_fail++;
    end
    n_checks++;
    if (out_data !== 16'h7FFF || sat_cnt !== 8'd1) begin
      $display("FAIL wrap_vs_sat: got d=%h cnt=%0d want 7FFF/1", out_data, sat_cnt); n_fail++;
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h00000011;
    step();
    out_ready = 1'b0; in_data = 32'h00000100;
    held = 16'h0011;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
        $display("FAIL stall_%0d: got rdy=%b v=%b d=%h want 0/1/%h", c, in_ready, out_valid, out_data, held);
        n_fail++;
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'h00000100 + 32'(k);
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0100 + 16'(k)) begin
        $display("FAIL stream_%0d: got v=%b d=%h want 1/%h", k, out_valid, out_data, 16'h0100 + 16'(k));
        n_fail++;
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0103) begin
      $display("FAIL stream_end: got v=%b d=%h want 0/0103", out_valid, out_data); n_fail++;
    end
  endtask

  task automatic test_counter();
    clr = 1'b1;
    step();
    clr = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_data = i[0] ? 32'h40000000 : 32'hC0000000;
      step();
      if (i == 253) begin
        n_checks++;
        if (sat_cnt !== 8'd254) begin
          $display("FAIL cnt_254: got %0d want 254", sat_cnt); n_fail++;
        end
      end
    end
    n_checks++;
    if (sat_cnt !== 8'd255 || ovf_sticky !== 1'b1) begin
      $display("FAIL cnt_ceiling: got cnt=%0d ovf=%b want 255/1", sat_cnt, ovf_sticky); n_fail++;
    end
    clr = 1'b1; in_data = 32'h7FFFFFFF;
    step();
    clr = 1'b0;
    n_checks++;
    if (sat_cnt !== 8'd0 || ovf_sticky !== 1'b0) begin
      $display("FAIL clr_priority: got cnt=%0d ovf=%b want 0/0", sat_cnt, ovf_sticky); n_fail++;
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h7FFF || out_sat !== 1'b1) begin
      $display("FAIL clr_datapath: got v=%b d=%h s=%b want 1/7FFF/1", out_valid, out_data, out_sat);
      n_fail++;
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h00010000;
    step();
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_data, out_sat, ovf_sticky, sat_cnt} !== 27'd0 || in_ready !== 1'b1) begin
      $display("FAIL reset_async: got v=%b d=%h s=%b ovf=%b cnt=%0d rdy=%b want 0s/rdy=1",
               out_valid, out_data, out_sat, ovf_sticky, sat_cnt, in_ready);
      n_fail++;
    end
    step(); step();
    #2 reset_n = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL reset_release: got rdy=%b v=%b want 1/0", in_ready, out_valid); n_fail++;
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h00001234;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_sat !== 1'b0) begin
      $display("FAIL reset_first_word: got v=%b d=%h s=%b want 1/1234/0", out_valid, out_data, out_sat);
      n_fail++;
    end
    step();
  endtask

  initial begin
    test_reset();
    test_in_range();
    test_saturate();
    test_wrap();
    test_backpressure();
    test_counter();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sign_narrow.md
SIGN_NARROW -- requirements
Module: sign_narrow

Interface
REQ-001 Parameter IN_W, default 32: width of the signed input word.
REQ-002 Parameter OUT_W, default 16: width of the signed output word; SHALL be less than IN_W.
REQ-003 Parameter SAT_EN, default 1: 1 selects saturation, 0 selects wrap (plain truncation).
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  in_data is valid this cycle.
REQ-007 in_ready  out  1  block accepts in_data this cycle.
REQ-008 in_data  in  IN_W  signed two's-complement input word.
REQ-009 out_valid  out  1  out_data is valid.
REQ-010 out_ready  in  1  consumer accepts out_data this cycle.
REQ-011 out_data  out  OUT_W  narrowed signed word.
REQ-012 out_sat  out  1  out_data is the narrowing of an out-of-range input.
REQ-013 clr  in  1  synchronous clear of ovf_sticky and sat_cnt.
REQ-014 ovf_sticky  out  1  at least one out-of-range input has been accepted since the last reset or clear.
REQ-015 sat_cnt  out  8  count of out-of-range inputs accepted; saturates at 255.

Function
REQ-016 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-017 in_ready SHALL equal !out_valid || out_ready (combinational; one output register, no bubble under continuous flow).
REQ-018 Latency: a word accepted in cycle N SHALL appear on out_data with out_valid=1 in cycle N+1.
REQ-019 Range check: the input is in range iff in_data[IN_W-1:OUT_W-1] are all equal.
REQ-020 In range: out_data = in_data[OUT_W-1:0] and out_sat = 0.
REQ-021 Out of range with SAT_EN=1: out_data = max positive (0x7FFF at default widths) if in_data[IN_W-1]=0, otherwise min negative (0x8000); out_sat = 1.
REQ-022 Out of range with SAT_EN=0: out_data = in_data[OUT_W-1:0]; out_sat = 1.
REQ-023 With out_valid=1 and out_ready=0, out_data, out_sat and out_valid SHALL hold; no input is accepted.
REQ-024 If an output transfer occurs with no input transfer in the same cycle, out_valid SHALL go to 0 next cycle; out_data holds its last value.
REQ-025 Simultaneous input and output transfer: the output register loads the new word and out_valid stays 1.
REQ-026 On each accepted out-of-range input: ovf_sticky is set to 1 and sat_cnt increments by 1, holding at 255 (no wrap).
REQ-027 clr=1 SHALL force ovf_sticky=0 and sat_cnt=0 next cycle; clr has priority over a same-cycle out-of-range acceptance, which is not counted.
REQ-028 clr SHALL NOT affect the data path, out_valid or the handshake.
REQ-029 Invariant: for an input already within the OUT_W range, narrowing followed by sign extension back to IN_W SHALL return the original word.

Reset
REQ-030 While reset_n=0, asynchronously and regardless of clk: out_valid=0, out_data=0, out_sat=0, ovf_sticky=0, sat_cnt=0.
REQ-031 A word held in the output register when reset asserts SHALL be discarded; in_ready=1 during reset and in the first cycle after release.
REQ-032 Reset release SHALL be synchronous to clk; no transfer occurs in the cycle reset deasserts.

Verification
REQ-033 In range: in_data 0xFFFF8001, then 0x00007FFF, with out_ready=1 -> out_data 0x8001 then 0x7FFF, out_sat=0, one cycle after each input.
REQ-034 Saturation (SAT_EN=1): inputs 0x00008000, then 0x80000000 -> out_data 0x7FFF then 0x8000, out_sat=1, ovf_sticky=1, sat_cnt=2.
REQ-035 Wrap (SAT_EN=0): input 0x00012345 -> out_data 0x2345, out_sat=1, sat_cnt=1.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data stable; raise out_ready -> one output transfer per cycle with no loss or duplication.
REQ-037 Counter ceiling and clear: 300 out-of-range inputs -> sat_cnt=255; clr together with an out-of-range input -> sat_cnt=0, ovf_sticky=0.
REQ-038 Reset mid-operation: assert reset_n=0 asynchronously while out_valid=1 -> all outputs 0 immediately; after release, the first accepted word appears at N+1.
